// File: rtl/fdiv_ctrl.sv
// Programmable timebase: run/stop/one-shot sequencer with a loadable divisor.
// Produces a one-cycle tick enable, a divided square wave and a tick counter.
module fdiv_ctrl #(
  parameter int unsigned CNT_W   = 27,
  parameter int unsigned DEF_DIV = 100000000,
  parameter int unsigned TCNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  input  logic              start,
  input  logic              oneshot,
  input  logic              stop,
  output logic              tick,
  output logic              clk_out,
  output logic              busy,
  output logic [TCNT_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SHOT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);
  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEF_DIV);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic                tick_q, tick_d;
  logic                clk_out_q, clk_out_d;
  logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]    half_div;
  logic                last_cycle;

  assign half_div   = div_q >> 1;
  assign last_cycle = (cnt_q == div_q - CNT_W'(1));

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tick      = tick_q;
  assign clk_out   = clk_out_q;
  assign tick_cnt  = tick_cnt_q;

  // State and datapath registers; reset aborts any run without a trailing tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= RESET_DIV;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Next-state, counter, divisor load and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    tick_cnt_d = tick_cnt_q;

    case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        // Divisors below 2 cannot produce a distinct high and low phase.
        if (cfg_valid) begin
          div_d = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
        end
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          tick_cnt_d = '0;
        end else if (oneshot) begin
          state_d = SHOT;
          cnt_d   = '0;
        end
      end

      RUN, SHOT: begin
        if (stop) begin
          state_d   = IDLE;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end else if (last_cycle) begin
          cnt_d      = '0;
          tick_d     = 1'b1;
          tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          if (state_q == RUN) begin
            clk_out_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == half_div) begin
            clk_out_d = 1'b0;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: run, reload, one-shot, stop, reset abort, tick_cnt wrap.
module tb_fdiv_ctrl;

  localparam int unsigned CNT_W   = 27;
  localparam int unsigned DEF_DIV = 10;
  localparam int unsigned TCNT_W  = 4;
  localparam int          TMOD    = 1 << TCNT_W;

  logic              clk_in = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic              start = 1'b0;
  logic              oneshot = 1'b0;
  logic              stop = 1'b0;
  logic              tick;
  logic              clk_out;
  logic              busy;
  logic [TCNT_W-1:0] tick_cnt;

  int checks = 0;
  int failures = 0;

  fdiv_ctrl #(
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV),
    .TCNT_W (TCNT_W)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .start    (start),
    .oneshot  (oneshot),
    .stop     (stop),
    .tick     (tick),
    .clk_out  (clk_out),
    .busy     (busy),
    .tick_cnt (tick_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic edge1();
    @(posedge clk_in);
    #1;
  endtask

  // Check a RUN interval of d*periods edges; cnt is 0 at entry.
  // cont=0: entry is the accepting edge (clk_out still low); cont=1: entry is a tick edge.
  task automatic check_run(input int d, input int periods, input int base, input bit cont);
    for (int k = 1; k <= d * periods; k++) begin
      edge1();
      chk("run_tick", 32'(tick), 32'((k % d) == 0));
      chk("run_clk_out", 32'(clk_out), 32'((cont || k >= d) && ((k % d) < (d / 2))));
      chk("run_tick_cnt", 32'(tick_cnt), 32'((base + k / d) % TMOD));
      chk("run_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    edge1();
    rst_n = 1'b1;
    edge1();

    // 1: default divisor 10, three periods
    start = 1'b1;
    edge1();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("t1_tick_cnt0", 32'(tick_cnt), 32'd0);
    check_run(10, 3, 0, 1'b0);
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    chk("t1_stop_busy", 32'(busy), 32'd0);
    chk("t1_stop_tick", 32'(tick), 32'd0);
    chk("t1_stop_tick_cnt", 32'(tick_cnt), 32'd3);

    // 2: load 4, reload attempt during RUN ignored, then clamp of 1 to 2
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(4);
    edge1();
    cfg_valid = 1'b0;
    start = 1'b1;
    edge1();
    start = 1'b0;
    check_run(4, 2, 0, 1'b0);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(7);
    chk("t2_cfg_ready_run", 32'(cfg_ready), 32'd0);
    check_run(4, 2, 2, 1'b1);
    cfg_valid = 1'b0;
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(1);
    edge1();
    cfg_valid = 1'b0;
    start = 1'b1;
    edge1();
    start = 1'b0;
    check_run(2, 3, 0, 1'b0);
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    chk("t2_tick_cnt_hold", 32'(tick_cnt), 32'd3);

    // 3: one-shot with divisor 6
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(6);
    edge1();
    cfg_valid = 1'b0;
    oneshot = 1'b1;
    edge1();
    oneshot = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_tick_cnt_keep", 32'(tick_cnt), 32'd3);
    for (int k = 1; k <= 5; k++) begin
      edge1();
      chk("t3_pre_tick", 32'(tick), 32'd0);
      chk("t3_pre_clk_out", 32'(clk_out), 32'd0);
      chk("t3_pre_busy", 32'(busy), 32'd1);
    end
    edge1();
    chk("t3_tick", 32'(tick), 32'd1);
    chk("t3_busy_fall", 32'(busy), 32'd0);
    chk("t3_clk_out", 32'(clk_out), 32'd0);
    chk("t3_tick_cnt", 32'(tick_cnt), 32'd4);
    edge1();
    chk("t3_single_tick", 32'(tick), 32'd0);
    start   = 1'b1;
    oneshot = 1'b1;
    edge1();
    start   = 1'b0;
    oneshot = 1'b0;
    check_run(6, 1, 0, 1'b0);
    stop = 1'b1;
    edge1();
    stop = 1'b0;

    // 4: stop at cnt==div-1 suppresses the tick
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(8);
    edge1();
    cfg_valid = 1'b0;
    start = 1'b1;
    edge1();
    start = 1'b0;
    check_run(8, 1, 0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      edge1();
      chk("t4_pre_tick", 32'(tick), 32'd0);
    end
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    chk("t4_stop_tick", 32'(tick), 32'd0);
    chk("t4_stop_busy", 32'(busy), 32'd0);
    chk("t4_stop_clk_out", 32'(clk_out), 32'd0);
    chk("t4_stop_tick_cnt", 32'(tick_cnt), 32'd1);
    edge1();
    chk("t4_after_tick", 32'(tick), 32'd0);
    start = 1'b1;
    edge1();
    start = 1'b0;
    edge1();
    edge1();
    start = 1'b1;
    stop  = 1'b1;
    edge1();
    start = 1'b0;
    stop  = 1'b0;
    chk("t4_startstop_busy", 32'(busy), 32'd0);

    // 5: async reset mid-RUN with clk_out high
    start = 1'b1;
    edge1();
    start = 1'b0;
    check_run(8, 1, 0, 1'b0);
    edge1();
    edge1();
    edge1();
    chk("t5_pre_clk_out", 32'(clk_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_clk_out", 32'(clk_out), 32'd0);
    chk("t5_tick", 32'(tick), 32'd0);
    chk("t5_tick_cnt", 32'(tick_cnt), 32'd0);
    chk("t5_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    edge1();
    edge1();
    rst_n = 1'b1;
    edge1();
    start = 1'b1;
    edge1();
    start = 1'b0;
    check_run(10, 1, 0, 1'b0);
    stop = 1'b1;
    edge1();
    stop = 1'b0;

    // 6: load and start on one edge, divisor 2, tick_cnt wraps; restart clears it
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(2);
    start     = 1'b1;
    edge1();
    cfg_valid = 1'b0;
    start     = 1'b0;
    check_run(2, 17, 0, 1'b0);
    chk("t6_wrapped", 32'(tick_cnt), 32'd1);
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    chk("t6_hold", 32'(tick_cnt), 32'd1);
    start = 1'b1;
    edge1();
    start = 1'b0;
    chk("t6_restart_clear", 32'(tick_cnt), 32'd0);
    chk("t6_restart_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdiv_ctrl.md
Name: fdiv_ctrl

Overview:
- Programmable timebase controller for the VGA design. Replaces the fixed 1 Hz divider with a run/stop/one-shot sequencer and a loadable divisor.
- Produces three outputs:
  - a single-cycle enable pulse `tick` for downstream counters and display logic;
  - a square-wave `clk_out`;
  - a running tick count.
- Sits between the board clock and the seconds/scroll logic that consumes the 1 Hz rate.

Parameters:
- CNT_W, 27, width of divisor and cycle counter.
- DEF_DIV, 100000000, divisor loaded at reset. With a 100 MHz `clk_in` this gives 1 Hz.
- TCNT_W, 16, width of tick_cnt.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  divisor load request.
- cfg_div  input  CNT_W  requested divisor (cycles per tick).
- cfg_ready  output  1  divisor may be loaded (high only in IDLE).
- start  input  1  begin free-running operation.
- oneshot  input  1  begin single-tick operation.
- stop  input  1  abort and return to IDLE.
- tick  output  1  one-cycle enable pulse, once per divisor period.
- clk_out  output  1  divided square wave (RUN only).
- busy  output  1  state is not IDLE.
- tick_cnt  output  TCNT_W  ticks emitted since last start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, div=DEF_DIV;
  - tick=0, clk_out=0, tick_cnt=0.
  - Reset asserted mid-operation aborts immediately, with no further tick.
- States: IDLE, RUN, SHOT.
  - busy = (state != IDLE).
  - cfg_ready = (state == IDLE), combinational.
- Divisor load:
  - The edge with cfg_valid && cfg_ready writes div = max(cfg_div, 2). Values 0 and 1 clamp to 2.
  - cfg_valid outside IDLE is ignored and produces no error.
  - A load takes effect on the next start or oneshot.
- IDLE transitions:
  - start → RUN; cnt=0 and tick_cnt=0 on the same edge.
  - oneshot → SHOT; cnt=0; tick_cnt unchanged.
  - start and oneshot together: start wins.
  - A load and a start on the same edge are both honoured; the new div applies to this run.
- RUN and SHOT counting:
  - cnt increments every cycle and wraps div-1 → 0.
  - The edge where cnt goes div-1 → 0 registers tick=1 for exactly one cycle and increments tick_cnt, which wraps modulo 2^TCNT_W.
  - First tick is high in the cycle beginning div edges after the accepting edge. Period is exactly div cycles.
- clk_out (RUN only, registered):
  - set to 1 on the tick edge;
  - cleared on the edge where cnt goes (div>>1)-1 → div>>1;
  - high time = div>>1 cycles, period = div;
  - 0 before the first tick.
- SHOT:
  - clk_out stays 0.
  - On the first tick edge the state returns to IDLE, so tick fires exactly once.
- stop in RUN or SHOT:
  - → IDLE on the next edge; cnt=0, clk_out=0;
  - no tick on that edge, even if cnt==div-1;
  - tick_cnt holds.
  - start+stop together in RUN: stop wins. stop in IDLE: no effect.
- start or oneshot while in RUN/SHOT: ignored.
- tick and clk_out are registered. No combinational path from any input to tick or clk_out.

Test Plan:
1. DEF_DIV=10, reset released, start pulse at edge E:
   - tick high in cycles E+10, E+20, E+30;
   - clk_out high 5 cycles, low 5;
   - tick_cnt 1,2,3; busy=1.
2. In IDLE, cfg_valid with cfg_div=4, then start:
   - tick every 4 cycles, clk_out 2 high/2 low.
   - cfg_valid with cfg_div=7 during RUN: cfg_ready=0, period stays 4.
   - cfg_div=1 in IDLE: period 2, clk_out alternates 1/0.
3. oneshot with div=6:
   - single tick 6 cycles later; busy falls on the same edge;
   - clk_out stays 0; tick_cnt +1.
   - oneshot and start together: RUN behaviour.
4. RUN with div=8, stop asserted while cnt==7:
   - no tick; busy=0 next cycle; clk_out=0; tick_cnt holds.
   - start+stop on the same edge in RUN: returns to IDLE.
5. rst_n pulled low mid-RUN (cnt=3, clk_out=1):
   - immediately clk_out=0, tick=0, tick_cnt=0, div=DEF_DIV, cfg_ready=1.
6. TCNT_W=4, div=2, run 17 ticks:
   - tick_cnt wraps 15 → 0 → 1.
   - A second start clears tick_cnt to 0.
